// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle radix-2^k restoring integer divider with valid/ready handshakes
//
// Shared long-latency divide unit between execute and writeback. Operands are
// converted to magnitudes on accept, the magnitude quotient is resolved
// BITS_PER_CYCLE bits per cycle (MSB first, restoring shift-subtract), then a
// single fix-up cycle applies signs and registers the result.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous reset, active-low
//   flush        synchronous abort of any in-flight operation
//   in_valid     operands valid
//   in_ready     divider idle and able to accept operands
//   dividend     numerator, WIDTH bits
//   divisor      denominator, WIDTH bits
//   is_signed    1 = two's-complement operation, 0 = unsigned
//   out_valid    result valid (held until out_ready)
//   out_ready    consumer accepts result
//   quotient     quotient, WIDTH bits
//   remainder    remainder, WIDTH bits
//   div_by_zero  divisor was zero for this result

module seq_divider #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // q_reg starts as the dividend magnitude and is shifted left as quotient
    // bits enter at the bottom; r_reg is the partial remainder.
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] d_reg;
    logic             neg_q;
    logic             neg_r;
    logic             zero_div;

    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;

    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] r_nxt;

    // Magnitudes of the incoming operands. The most negative value negates to
    // itself, which read as unsigned is exactly its magnitude 2^(WIDTH-1).
    assign dvd_neg = is_signed & dividend[WIDTH-1];
    assign dvs_neg = is_signed & divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? -dividend : dividend;
    assign dvs_mag = dvs_neg ? -divisor : divisor;

    // Gated by rst_n so the unit never advertises readiness while held in reset.
    assign in_ready = rst_n && (state == IDLE);

    // One iteration: BITS_PER_CYCLE restoring steps chained combinationally.
    // The working remainder is one bit wider because 2*r+1 can exceed WIDTH
    // bits when the divisor magnitude is close to 2^WIDTH.
    always_comb begin
        logic [WIDTH:0]   r_t;
        logic [WIDTH-1:0] q_t;
        r_t = {1'b0, r_reg};
        q_t = q_reg;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            r_t = {r_t[WIDTH-1:0], q_t[WIDTH-1]};
            q_t = {q_t[WIDTH-2:0], 1'b0};
            if (r_t >= {1'b0, d_reg}) begin
                r_t    = r_t - {1'b0, d_reg};
                q_t[0] = 1'b1;
            end
        end
        q_nxt = q_t;
        r_nxt = r_t[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            q_reg       <= '0;
            r_reg       <= '0;
            d_reg       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            zero_div    <= 1'b0;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (flush) begin
            // Abort: result registers may keep stale data, only the status drops.
            state       <= IDLE;
            out_valid   <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        zero_div <= (divisor == '0);
                        neg_q    <= dvd_neg ^ dvs_neg;
                        neg_r    <= dvd_neg;
                        d_reg    <= dvs_mag;
                        r_reg    <= '0;
                        cnt      <= CNT_W'(N);
                        if (divisor == '0) begin
                            // Keep the raw dividend; it is returned as the
                            // remainder. Routing through FIX puts out_valid
                            // one edge after the accept edge.
                            q_reg <= dividend;
                            state <= FIX;
                        end else begin
                            q_reg <= dvd_mag;
                            state <= RUN;
                        end
                    end
                end

                RUN: begin
                    if (cnt == '0) begin
                        state <= FIX;
                    end else begin
                        q_reg <= q_nxt;
                        r_reg <= r_nxt;
                        cnt   <= cnt - CNT_W'(1);
                    end
                end

                FIX: begin
                    if (zero_div) begin
                        quotient    <= '1;
                        remainder   <= q_reg;
                        div_by_zero <= 1'b1;
                    end else begin
                        // neg_q/neg_r are only ever set in signed mode, so an
                        // unsigned operation passes through unchanged.
                        quotient    <= neg_q ? -q_reg : q_reg;
                        remainder   <= neg_r ? -r_reg : r_reg;
                        div_by_zero <= 1'b0;
                    end
                    out_valid <= 1'b1;
                    state     <= DONE;
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed and reference-model checks for seq_divider

module tb_seq_divider;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        sel4;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        is_signed;
    logic        out_ready;

    logic        in_valid1, in_ready1, out_valid1, dz1;
    logic [31:0] q1, r1;
    logic        in_valid4, in_ready4, out_valid4, dz4;
    logic [31:0] q4, r4;

    logic        m_in_ready, m_out_valid, m_dz;
    logic [31:0] m_q, m_r;

    int          errors;
    int          checks;

    assign in_valid1 = in_valid && !sel4;
    assign in_valid4 = in_valid && sel4;

    assign m_in_ready  = sel4 ? in_ready4  : in_ready1;
    assign m_out_valid = sel4 ? out_valid4 : out_valid1;
    assign m_dz        = sel4 ? dz4        : dz1;
    assign m_q         = sel4 ? q4         : q1;
    assign m_r         = sel4 ? r4         : r1;

    seq_divider #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid1),
        .in_ready    (in_ready1),
        .dividend    (dividend),
        .divisor     (divisor),
        .is_signed   (is_signed),
        .out_valid   (out_valid1),
        .out_ready   (out_ready),
        .quotient    (q1),
        .remainder   (r1),
        .div_by_zero (dz1)
    );

    seq_divider #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid4),
        .in_ready    (in_ready4),
        .dividend    (dividend),
        .divisor     (divisor),
        .is_signed   (is_signed),
        .out_valid   (out_valid4),
        .out_ready   (out_ready),
        .quotient    (q4),
        .remainder   (r4),
        .div_by_zero (dz4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Independent reference built on native 64-bit arithmetic.
    task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output logic [31:0] q, output logic [31:0] r, output logic z);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else begin
            if (s) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'd0, a});
                sb = longint'({32'd0, b});
            end
            q = 32'(sa / sb);
            r = 32'(sa % sb);
            z = 1'b0;
        end
    endtask

    // Full operation with out_ready high: accept, latency, busy in_ready,
    // result values, and return to idle one edge after out_valid.
    task automatic do_op(input string tag, input logic use4,
                         input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] eq, input logic [31:0] er, input logic ez,
                         input int elat);
        int   lat;
        logic busy_ok;
        @(negedge clk);
        sel4      = use4;
        dividend  = a;
        divisor   = b;
        is_signed = s;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check({tag, ".in_ready_idle"}, 32'(m_in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        lat      = 0;
        busy_ok  = 1'b1;
        while (m_out_valid !== 1'b1 && lat < 100) begin
            if (m_in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(elat));
        check({tag, ".in_ready_busy"}, 32'(busy_ok), 32'd1);
        check({tag, ".quotient"}, m_q, eq);
        check({tag, ".remainder"}, m_r, er);
        check({tag, ".div_by_zero"}, 32'(m_dz), 32'(ez));
        @(posedge clk);
        #1;
        check({tag, ".out_valid_drop"}, 32'(m_out_valid), 32'd0);
        check({tag, ".in_ready_back"}, 32'(m_in_ready), 32'd1);
    endtask

    // Accept an operation on the BITS_PER_CYCLE=1 unit and leave it in RUN
    // after ten iteration edges.
    task automatic start_and_run10(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        sel4      = 1'b0;
        dividend  = a;
        divisor   = b;
        is_signed = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("run10.in_ready", 32'(in_ready1), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rq;
        logic [31:0] rr;
        logic        rz;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic        seen;

        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        sel4      = 1'b0;
        dividend  = '0;
        divisor   = '0;
        is_signed = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset.in_ready", 32'(in_ready1), 32'd0);
        check("reset.out_valid", 32'(out_valid1), 32'd0);
        check("reset.quotient", q1, 32'd0);
        check("reset.remainder", r1, 32'd0);
        check("reset.div_by_zero", 32'(dz1), 32'd0);
        check("reset.out_valid4", 32'(out_valid4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Main function, BITS_PER_CYCLE=1: latency N+2 = 34
        do_op("u100_7",   1'b0, 32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 34);
        do_op("s-7_2",    1'b0, 32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 34);
        do_op("u-7_2",    1'b0, 32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1,          1'b0, 34);
        do_op("s7_-2",    1'b0, 32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0, 34);
        do_op("s-7_-2",   1'b0, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'd3,          32'hFFFF_FFFF,  1'b0, 34);

        // Divide by zero, both modes, then a normal op clears the flag
        do_op("u5_0",     1'b0, 32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          1'b1, 1);
        do_op("s5_0",     1'b0, 32'd5,          32'd0,          1'b1, 32'hFFFF_FFFF,  32'd5,          1'b1, 1);
        do_op("u9_3",     1'b0, 32'd9,          32'd3,          1'b0, 32'd3,          32'd0,          1'b0, 34);

        // Boundaries
        do_op("smin_-1",  1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0, 34);
        do_op("umax_1",   1'b0, 32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0, 34);
        do_op("u3_7",     1'b0, 32'd3,          32'd7,          1'b0, 32'd0,          32'd3,          1'b0, 34);

        // Backpressure: result held for 5 cycles, in_valid pulses ignored
        @(negedge clk);
        sel4      = 1'b0;
        dividend  = 32'd1000;
        divisor   = 32'd10;
        is_signed = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 100 && out_valid1 !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        check("bp.out_valid_rise", 32'(out_valid1), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i % 2) == 0;
            dividend = 32'd7;
            divisor  = 32'd0;
            @(posedge clk);
            #1;
            check("bp.out_valid", 32'(out_valid1), 32'd1);
            check("bp.quotient", q1, 32'd100);
            check("bp.remainder", r1, 32'd0);
            check("bp.div_by_zero", 32'(dz1), 32'd0);
            check("bp.in_ready", 32'(in_ready1), 32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp.release_out_valid", 32'(out_valid1), 32'd0);
        check("bp.release_in_ready", 32'(in_ready1), 32'd1);

        // Flush at RUN cycle 10: out_valid never rises
        start_and_run10(32'd77, 32'd5);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush.in_ready", 32'(in_ready1), 32'd1);
        check("flush.out_valid", 32'(out_valid1), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid1 !== 1'b0) seen = 1'b1;
        end
        check("flush.no_result", 32'(seen), 32'd0);

        // Flush together with in_valid in IDLE: not accepted
        @(negedge clk);
        dividend = 32'd50;
        divisor  = 32'd5;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_idle.in_ready", 32'(in_ready1), 32'd1);
        do_op("post_flush_9_3", 1'b0, 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 34);

        // Reset mid-RUN clears every output
        start_and_run10(32'd50, 32'd5);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst.in_ready", 32'(in_ready1), 32'd0);
        check("midrst.out_valid", 32'(out_valid1), 32'd0);
        check("midrst.quotient", q1, 32'd0);
        check("midrst.remainder", r1, 32'd0);
        check("midrst.div_by_zero", 32'(dz1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("post_rst_9_3", 1'b0, 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 34);

        // BITS_PER_CYCLE=4: latency N+2 = 10
        do_op("b4_u100_7",  1'b1, 32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         1'b0, 10);
        do_op("b4_s-7_2",   1'b1, 32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 10);
        do_op("b4_smin_-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,         1'b0, 10);
        do_op("b4_u5_0",    1'b1, 32'd5,         32'd0,         1'b0, 32'hFFFF_FFFF, 32'd5,         1'b1, 1);

        // BITS_PER_CYCLE=4 randomized against the reference model
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            rs = 1'(($urandom >> 3) & 1);
            if ((i % 4) == 3) rb = -rb;
            ref_div(ra, rb, rs, rq, rr, rz);
            do_op("b4_rand", 1'b1, ra, rb, rs, rq, rr, rz, (rb == 32'd0) ? 1 : 10);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
